// File: rtl/tcdm_sram_responder.sv
// TCDM slave backed by a single-port word-addressed SRAM: one-cycle responses,
// byte-enabled writes, LFSR-injected grant stalls and saturating activity counters.
module tcdm_sram_responder #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_SIZE  = 128,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int unsigned STALL_THRESH = 0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    enable_i,
  input  logic                    tcdm_req_i,
  output logic                    tcdm_gnt_o,
  input  logic [31:0]             tcdm_add_i,
  input  logic                    tcdm_wen_i,
  input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_data_i,
  output logic [DATA_WIDTH-1:0]   tcdm_r_data_o,
  output logic                    tcdm_r_valid_o,
  output logic [31:0]             n_reads_o,
  output logic [31:0]             n_writes_o,
  output logic [31:0]             n_stalls_o,
  output logic                    err_o
);

  localparam int unsigned BW   = DATA_WIDTH / 8;
  localparam int unsigned OFFS = (BW > 1) ? $clog2(BW) : 0;
  localparam int unsigned IW   = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;

  logic [DATA_WIDTH-1:0] mem_q [MEMORY_SIZE];

  logic [32:0]           diff;
  logic [31:0]           idx_full;
  logic [IW-1:0]         idx;
  logic                  in_range, gnt, accept, do_clr;
  logic [15:0]           lfsr_q, lfsr_d;
  logic                  stall_q, stall_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [31:0]           nrd_q, nrd_d, nwr_q, nwr_d, nst_q, nst_d;
  logic                  err_q, err_d;

  // The 33rd bit of the subtraction is the borrow, i.e. add below BASE_ADDR.
  assign diff     = {1'b0, tcdm_add_i} - {1'b0, BASE_ADDR};
  assign idx_full = diff[31:0] >> OFFS;
  assign in_range = ~diff[32] & (idx_full < 32'(MEMORY_SIZE));
  assign idx      = idx_full[IW-1:0];

  assign gnt    = tcdm_req_i & enable_i & ~stall_q;
  assign accept = tcdm_req_i & gnt;
  assign do_clr = rst_i | clear_i;

  always_comb begin
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    stall_d  = ({24'd0, lfsr_q[7:0]} < STALL_THRESH);
    rvalid_d = accept;
    rdata_d  = (accept & tcdm_wen_i & in_range) ? mem_q[idx] : '0;
    err_d    = err_q | (accept & ~in_range);
    nrd_d    = nrd_q;
    nwr_d    = nwr_q;
    nst_d    = nst_q;
    if (accept &  tcdm_wen_i & (nrd_q != '1)) nrd_d = nrd_q + 32'd1;
    if (accept & ~tcdm_wen_i & (nwr_q != '1)) nwr_d = nwr_q + 32'd1;
    if (tcdm_req_i & ~gnt & (nst_q != '1))    nst_d = nst_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (do_clr) begin
      lfsr_q   <= LFSR_SEED;
      stall_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      nrd_q    <= '0;
      nwr_q    <= '0;
      nst_q    <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      stall_q  <= stall_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      nrd_q    <= nrd_d;
      nwr_q    <= nwr_d;
      nst_q    <= nst_d;
    end
  end

  // Storage is never reset; a reset/clear on the accepting edge suppresses the write.
  always_ff @(posedge clk_i) begin
    if (accept & ~tcdm_wen_i & in_range & ~do_clr) begin
      for (int i = 0; i < BW; i++)
        if (tcdm_be_i[i]) mem_q[idx][8*i +: 8] <= tcdm_data_i[8*i +: 8];
    end
  end

  assign tcdm_gnt_o     = gnt;
  assign tcdm_r_valid_o = rvalid_q;
  assign tcdm_r_data_o  = rdata_q;
  assign n_reads_o      = nrd_q;
  assign n_writes_o     = nwr_q;
  assign n_stalls_o     = nst_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_tcdm_sram_responder.sv
// Bench: two responders (no stalls / STALL_THRESH=128) against a word-array memory model.
module tb_tcdm_sram_responder;
  localparam int MS = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, en;
  int          sel;
  logic        req_v, wen_v;
  logic [31:0] add_v, data_v;
  logic [3:0]  be_v;

  logic        gnt0, rv0, e0, gnt1, rv1, e1;
  logic [31:0] rd0, nr0, nw0, ns0, rd1, nr1, nw1, ns1;

  tcdm_sram_responder #(.STALL_THRESH(0)) u0 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .enable_i(en),
    .tcdm_req_i(req_v && sel == 0), .tcdm_gnt_o(gnt0), .tcdm_add_i(add_v),
    .tcdm_wen_i(wen_v), .tcdm_be_i(be_v), .tcdm_data_i(data_v),
    .tcdm_r_data_o(rd0), .tcdm_r_valid_o(rv0),
    .n_reads_o(nr0), .n_writes_o(nw0), .n_stalls_o(ns0), .err_o(e0));

  tcdm_sram_responder #(.STALL_THRESH(128)) u1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .enable_i(en),
    .tcdm_req_i(req_v && sel == 1), .tcdm_gnt_o(gnt1), .tcdm_add_i(add_v),
    .tcdm_wen_i(wen_v), .tcdm_be_i(be_v), .tcdm_data_i(data_v),
    .tcdm_r_data_o(rd1), .tcdm_r_valid_o(rv1),
    .n_reads_o(nr1), .n_writes_o(nw1), .n_stalls_o(ns1), .err_o(e1));

  // reference model
  logic [31:0] mem_m [2][MS];
  int unsigned nr_m [2], nw_m [2], ns_m [2];
  bit          err_m [2];
  bit          exp_rv, obs_gnt, obs_rv;
  logic [31:0] exp_rd, obs_rd;
  int          n_cmp = 0, n_fail = 0;

  task automatic step(input int s, input bit rq, input bit wn, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d);
    logic [31:0] widx;
    @(negedge clk);
    sel = s; req_v = rq; wen_v = wn; add_v = a; be_v = b; data_v = d;
    #1 obs_gnt = (s == 0) ? gnt0 : gnt1;
    @(posedge clk);
    exp_rv = 1'b0; exp_rd = 32'h0;
    if (rst || clr) begin
      for (int k = 0; k < 2; k++) begin
        nr_m[k] = 0; nw_m[k] = 0; ns_m[k] = 0; err_m[k] = 1'b0;
      end
    end else if (rq && !obs_gnt) begin
      ns_m[s]++;
    end else if (rq) begin
      widx = a >> 2;
      exp_rv = 1'b1;
      if (widx >= MS) err_m[s] = 1'b1;
      if (wn) begin
        nr_m[s]++;
        if (widx < MS) exp_rd = mem_m[s][widx];
      end else begin
        nw_m[s]++;
        if (widx < MS)
          for (int i = 0; i < 4; i++)
            if (b[i]) mem_m[s][widx][8*i +: 8] = d[8*i +: 8];
      end
    end
    #1;
    obs_rv = (s == 0) ? rv0 : rv1;
    obs_rd = (s == 0) ? rd0 : rd1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; en = 1'b1;
    step(0, 0, 1, 0, 4'hF, 0);
    step(1, 0, 1, 0, 4'hF, 0);
    n_cmp++; if (rv0 !== 1'b0 || rv1 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b/%b want 0/0", rv0, rv1); end
    n_cmp++; if (rd0 !== 32'h0 || rd1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0", rd0, rd1); end
    n_cmp++; if ({nr0, nw0, ns0, nr1, nw1, ns1} !== '0) begin n_fail++; $display("FAIL reset_counters: got %0d %0d %0d %0d %0d %0d want 0", nr0, nw0, ns0, nr1, nw1, ns1); end
    n_cmp++; if (e0 !== 1'b0 || e1 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b/%b want 0", e0, e1); end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    step(0, 1, 0, 32'h8, 4'hF, 32'hCAFEBABE);
    n_cmp++; if (obs_gnt !== 1'b1 || obs_rv !== 1'b1) begin n_fail++; $display("FAIL wr_gnt_rvalid: got gnt=%b rv=%b want 1/1", obs_gnt, obs_rv); end
    n_cmp++; if (obs_rd !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h want 0", obs_rd); end
    step(0, 1, 1, 32'h8, 4'hF, 32'h0);
    n_cmp++; if (obs_gnt !== 1'b1 || obs_rv !== 1'b1) begin n_fail++; $display("FAIL rd_gnt_rvalid: got gnt=%b rv=%b want 1/1", obs_gnt, obs_rv); end
    n_cmp++; if (obs_rd !== 32'hCAFEBABE) begin n_fail++; $display("FAIL rd_data: got %h want cafebabe", obs_rd); end
    n_cmp++; if (nw0 !== 32'd1 || nr0 !== 32'd1) begin n_fail++; $display("FAIL wr_rd_counts: got w=%0d r=%0d want 1/1", nw0, nr0); end
    step(0, 0, 1, 32'h8, 4'hF, 32'h0);
    n_cmp++; if (obs_rv !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid: got %b want 0", obs_rv); end
  endtask

  task automatic test_byte_en();
    step(0, 1, 0, 32'h4, 4'hF, 32'h11223344);
    step(0, 1, 0, 32'h4, 4'b0101, 32'hAABBCCDD);
    step(0, 1, 1, 32'h4, 4'hF, 32'h0);
    n_cmp++; if (obs_rd !== 32'h11BB33DD || obs_rv !== 1'b1) begin n_fail++; $display("FAIL byte_en: got %h rv=%b want 11bb33dd", obs_rd, obs_rv); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) step(0, 1, 0, 32'(4 * i), 4'hF, 32'(i));
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1, 32'(4 * i), 4'hF, 32'h0);
      n_cmp++; if (obs_rv !== 1'b1 || obs_rd !== 32'(i)) begin n_fail++; $display("FAIL b2b_%0d: got rv=%b data=%h want 1/%h", i, obs_rv, obs_rd, i); end
    end
  endtask

  task automatic test_raw();
    logic [31:0] a, d;
    for (int i = 0; i < 10; i++) begin
      a = $urandom_range(0, MS - 1) << 2;
      d = $urandom;
      step(0, 1, 0, a, 4'hF, d);
      step(0, 1, 1, a | 32'($urandom_range(0, 3)), 4'hF, 32'h0);
      n_cmp++; if (obs_rd !== d) begin n_fail++; $display("FAIL raw_%0d: got %h want %h", i, obs_rd, d); end
    end
  endtask

  task automatic test_random();
    bit rq, wn;
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 9) != 0);
      rq = ($urandom_range(0, 3) != 0);
      wn = $urandom_range(0, 1);
      a  = ($urandom_range(0, 19) == 0) ? 32'(4 * MS + $urandom_range(0, 255))
                                        : 32'($urandom_range(0, 4 * MS - 1));
      step(0, rq, wn, a, 4'($urandom), $urandom);
      n_cmp++; if (obs_gnt !== (rq && en)) begin n_fail++; $display("FAIL rand_gnt_%0d: got %b want %b", i, obs_gnt, rq && en); end
      n_cmp++; if (obs_rv !== exp_rv || (exp_rv && obs_rd !== exp_rd)) begin n_fail++; $display("FAIL rand_resp_%0d: got rv=%b data=%h want rv=%b data=%h", i, obs_rv, obs_rd, exp_rv, exp_rd); end
    end
    en = 1'b1;
    n_cmp++; if (nr0 !== nr_m[0] || nw0 !== nw_m[0] || ns0 !== ns_m[0] || e0 !== err_m[0]) begin n_fail++; $display("FAIL rand_counts: got r=%0d w=%0d s=%0d e=%b want %0d %0d %0d %b", nr0, nw0, ns0, e0, nr_m[0], nw_m[0], ns_m[0], err_m[0]); end
  endtask

  task automatic test_out_of_range();
    int bad = 0;
    clr = 1'b1; step(0, 0, 1, 0, 4'hF, 0); clr = 1'b0;
    for (int i = 0; i < MS; i++) step(0, 1, 0, 32'(4 * i), 4'hF, $urandom);
    step(0, 1, 1, 32'(4 * MS), 4'hF, 32'h0);
    n_cmp++; if (obs_rv !== 1'b1 || obs_rd !== 32'h0) begin n_fail++; $display("FAIL oor_read: got rv=%b data=%h want 1/0", obs_rv, obs_rd); end
    n_cmp++; if (e0 !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b want 1", e0); end
    step(0, 1, 0, 32'(4 * MS), 4'hF, 32'hFFFFFFFF);
    step(0, 1, 0, 32'(4 * MS + 1000), 4'hF, 32'h5A5A5A5A);
    for (int i = 0; i < MS; i++) begin
      step(0, 1, 1, 32'(4 * i), 4'hF, 32'h0);
      if (obs_rd !== exp_rd) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL oor_mem_intact: got %0d differing words want 0", bad); end
    n_cmp++; if (nw0 !== 32'(MS + 2) || nr0 !== 32'(MS + 1)) begin n_fail++; $display("FAIL oor_counts: got w=%0d r=%0d want %0d/%0d", nw0, nr0, MS + 2, MS + 1); end
    clr = 1'b1; step(0, 0, 1, 0, 4'hF, 0); clr = 1'b0;
    n_cmp++; if (e0 !== 1'b0 || {nr0, nw0, ns0} !== '0) begin n_fail++; $display("FAIL clear: got e=%b r=%0d w=%0d s=%0d want 0", e0, nr0, nw0, ns0); end
  endtask

  task automatic test_reset_mid();
    step(0, 1, 0, 32'h10, 4'hF, 32'hDEADBEEF);
    step(0, 1, 1, 32'h10, 4'hF, 32'h0);
    n_cmp++; if (obs_rv !== 1'b1 || obs_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pre_rst_read: got rv=%b data=%h want 1/deadbeef", obs_rv, obs_rd); end
    rst = 1'b1;
    step(0, 1, 0, 32'h10, 4'hF, 32'h0);
    rst = 1'b0;
    n_cmp++; if (rv0 !== 1'b0 || rd0 !== 32'h0 || e0 !== 1'b0 || {nr0, nw0, ns0} !== '0) begin n_fail++; $display("FAIL mid_rst: got rv=%b data=%h e=%b r=%0d w=%0d s=%0d want all 0", rv0, rd0, e0, nr0, nw0, ns0); end
    step(0, 1, 1, 32'h10, 4'hF, 32'h0);
    n_cmp++; if (obs_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL post_rst_mem: got %h want deadbeef", obs_rd); end
  endtask

  // master holds its request until granted, within a cycle budget
  task automatic issue1(input bit wn, input logic [31:0] a, input logic [31:0] d, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 64 && !ok; t++) begin
      step(1, 1, wn, a, 4'hF, d);
      if (obs_rv !== exp_rv || (exp_rv && obs_rd !== exp_rd)) begin
        n_fail++; $display("FAIL stall_resp: got rv=%b data=%h want rv=%b data=%h", obs_rv, obs_rd, exp_rv, exp_rd);
      end
      ok = exp_rv;
    end
  endtask

  task automatic test_stalls();
    bit ok;
    int rv_cnt = 0, tmo = 0;
    for (int i = 0; i < 16; i++) begin
      issue1(1'b0, 32'(4 * i), $urandom, ok);
      if (!ok) tmo++;
    end
    clr = 1'b1; step(1, 0, 1, 0, 4'hF, 0); clr = 1'b0;
    for (int i = 0; i < 100; i++) begin
      issue1(1'b1, 32'(4 * $urandom_range(0, 15)), 32'h0, ok);
      n_cmp++;
      if (!ok) tmo++;
      if (obs_rv === 1'b1) rv_cnt++;
    end
    step(1, 0, 1, 0, 4'hF, 0);
    n_cmp++; if (tmo != 0) begin n_fail++; $display("FAIL stall_timeout: got %0d expired requests want 0", tmo); end
    n_cmp++; if (rv_cnt != 100) begin n_fail++; $display("FAIL stall_rvalid_count: got %0d want 100", rv_cnt); end
    n_cmp++; if (nr1 !== 32'd100) begin n_fail++; $display("FAIL stall_reads: got %0d want 100", nr1); end
    n_cmp++; if (ns1 !== ns_m[1] || ns_m[1] == 0) begin n_fail++; $display("FAIL stall_count: got %0d want %0d (nonzero)", ns1, ns_m[1]); end
  endtask

  initial begin
    sel = 0; req_v = 1'b0; wen_v = 1'b1; add_v = '0; data_v = '0; be_v = '0;
    rst = 1'b1; clr = 1'b0; en = 1'b1;
    test_reset();
    test_write_read();
    test_byte_en();
    test_back_to_back();
    test_raw();
    test_random();
    test_out_of_range();
    test_reset_mid();
    test_stalls();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
